// File: rtl/bridge_arbiter.sv
// Round-robin arbiter that shares one AXI-lite bridge command port between
// N_REQ requesters. Only one bridge transaction is outstanding at a time. The
// response is routed back to the requester that owns the transaction. A
// watchdog aborts a transaction that the bridge never completes.
module bridge_arbiter #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_r_wb,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]         req_ack,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic                     rsp_err,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     C_in_valid,
    output logic                     C_r_wb,
    output logic [ADDR_W-1:0]        C_addr,
    output logic [DATA_W-1:0]        C_data_w,
    input  logic                     C_out_valid,
    input  logic [DATA_W-1:0]        C_data_r
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [7:0]         wd_cnt;

    logic [ADDR_W-1:0]  addr_arr  [N_REQ];
    logic [DATA_W-1:0]  wdata_arr [N_REQ];

    logic               grant_any;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W:0]     probe;
    logic [PTR_W-1:0]   next_ptr;

    // Unpack the flattened request buses so they can be indexed by requester
    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    // Pick the first valid requester at or after rr_ptr, wrapping modulo N_REQ
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        probe     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            probe = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (probe >= (PTR_W+1)'(N_REQ)) begin
                probe = probe - (PTR_W+1)'(N_REQ);
            end
            if (!grant_any && req_valid[probe[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = probe[PTR_W-1:0];
            end
        end
    end

    // Rotation pointer moves to the requester just after the current owner
    assign next_ptr = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

    // Transaction FSM; every output is a register so the bridge sees clean strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            wd_cnt     <= '0;
            req_ack    <= '0;
            rsp_valid  <= '0;
            rsp_err    <= 1'b0;
            rsp_data   <= '0;
            C_in_valid <= 1'b0;
            C_r_wb     <= 1'b0;
            C_addr     <= '0;
            C_data_w   <= '0;
        end else begin
            req_ack    <= '0;
            rsp_valid  <= '0;
            C_in_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner      <= grant_idx;
                        C_r_wb     <= req_r_wb[grant_idx];
                        C_addr     <= addr_arr[grant_idx];
                        C_data_w   <= wdata_arr[grant_idx];
                        req_ack    <= N_REQ'(1) << grant_idx;
                        C_in_valid <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    rr_ptr <= next_ptr;
                    wd_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + 8'd1;
                    // A completion beats the watchdog when both land together
                    if (C_out_valid) begin
                        rsp_valid <= N_REQ'(1) << owner;
                        rsp_err   <= 1'b0;
                        rsp_data  <= C_r_wb ? C_data_r : '0;
                        state     <= RESP;
                    end else if (wd_cnt == 8'(TIMEOUT - 1)) begin
                        rsp_valid <= N_REQ'(1) << owner;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rsp_err  <= 1'b0;
                    rsp_data <= '0;
                    wd_cnt   <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bridge_arbiter.sv
// Scoreboard bench for bridge_arbiter: stimulus pushes expected grants and
// responses into queues, and independent monitors pop and compare them.
module tb_bridge_arbiter;

    localparam int N  = 2;
    localparam int AW = 8;
    localparam int DW = 64;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_r_wb;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ack;
    logic [N-1:0]    rsp_valid;
    logic            rsp_err;
    logic [DW-1:0]   rsp_data;
    logic            C_in_valid;
    logic            C_r_wb;
    logic [AW-1:0]   C_addr;
    logic [DW-1:0]   C_data_w;
    logic            C_out_valid;
    logic [DW-1:0]   C_data_r;

    bridge_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_r_wb(req_r_wb), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ack(req_ack), .rsp_valid(rsp_valid),
        .rsp_err(rsp_err), .rsp_data(rsp_data), .C_in_valid(C_in_valid),
        .C_r_wb(C_r_wb), .C_addr(C_addr), .C_data_w(C_data_w),
        .C_out_valid(C_out_valid), .C_data_r(C_data_r)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0]  ack;
        logic          r_wb;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } grant_t;

    typedef struct {
        logic [N-1:0]  vld;
        logic          err;
        logic [DW-1:0] data;
        int            at;
    } rsp_t;

    grant_t gq[$];
    rsp_t   rq[$];

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void push_grant(input int id, input logic r_wb,
                                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        grant_t g;
        g.ack   = (id == 0) ? 2'b01 : 2'b10;
        g.r_wb  = r_wb;
        g.addr  = addr;
        g.wdata = wdata;
        gq.push_back(g);
    endfunction

    // Grant monitor: ack and command strobe must appear together with latched fields
    always @(negedge clk) begin : mon_grant
        grant_t g;
        if (req_ack != '0 || C_in_valid) begin
            if (gq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got ack=%b cin=%b expected none",
                         req_ack, C_in_valid);
            end else begin
                g = gq.pop_front();
                check("req_ack", 64'(req_ack), 64'(g.ack));
                check("C_in_valid", 64'(C_in_valid), 64'd1);
                check("C_r_wb", 64'(C_r_wb), 64'(g.r_wb));
                check("C_addr", 64'(C_addr), 64'(g.addr));
                check("C_data_w", C_data_w, g.wdata);
            end
        end
    end

    // Response monitor: owner, error flag, data and arrival cycle
    always @(negedge clk) begin : mon_rsp
        rsp_t r;
        if (rsp_valid != '0) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=%b expected none", rsp_valid);
            end else begin
                r = rq.pop_front();
                check("rsp_valid", 64'(rsp_valid), 64'(r.vld));
                check("rsp_err", 64'(rsp_err), 64'(r.err));
                check("rsp_data", rsp_data, r.data);
                check("rsp_cycle", 64'(cyc), 64'(r.at));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero();
        @(negedge clk);
        check("rst_req_ack", 64'(req_ack), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_C_in_valid", 64'(C_in_valid), 64'd0);
        check("rst_C_r_wb", 64'(C_r_wb), 64'd0);
        check("rst_C_addr", 64'(C_addr), 64'd0);
        check("rst_C_data_w", C_data_w, 64'd0);
    endtask

    // Raise a request and hold it until acked; optionally check grant latency
    task automatic request(input int id, input logic r_wb, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input bit lat_chk);
        int start;
        bit got;
        got = 1'b0;
        req_r_wb[id]            = r_wb;
        req_addr[id*AW +: AW]   = addr;
        req_wdata[id*DW +: DW]  = wdata;
        req_valid[id]           = 1'b1;
        start = cyc;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            if (req_ack[id]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_wait: got no ack for requester %0d expected ack", id);
        end else if (lat_chk) begin
            check("ack_latency", 64'(cyc - start), 64'd1);
        end
        req_valid[id] = 1'b0;
    endtask

    // Bridge model: waits for a command, then completes it after delay cycles or stays silent
    task automatic bridge(input int owner, input int delay, input bit silent,
                          input logic [DW-1:0] rdata, input logic [DW-1:0] exp_data);
        int   c;
        bit   got;
        rsp_t r;
        got = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (C_in_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL cmd_wait: got no C_in_valid expected command for %0d", owner);
            return;
        end
        c     = cyc;
        r.vld = (owner == 0) ? 2'b01 : 2'b10;
        if (silent) begin
            r.err  = 1'b1;
            r.data = '0;
            r.at   = c + TO + 1;
            rq.push_back(r);
        end else begin
            r.err  = 1'b0;
            r.data = exp_data;
            r.at   = c + delay + 1;
            rq.push_back(r);
            repeat (delay) @(posedge clk);
            #1;
            C_out_valid = 1'b1;
            C_data_r    = rdata;
            @(posedge clk);
            #1;
            C_out_valid = 1'b0;
            C_data_r    = '0;
        end
    endtask

    task automatic stray_pulse(input logic [DW-1:0] d);
        C_out_valid = 1'b1;
        C_data_r    = d;
        @(posedge clk);
        #1;
        C_out_valid = 1'b0;
        C_data_r    = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected end of run");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst         = 1'b1;
        req_valid   = '0;
        req_r_wb    = '0;
        req_addr    = '0;
        req_wdata   = '0;
        C_out_valid = 1'b0;
        C_data_r    = '0;
        repeat (2) @(posedge clk);
        check_zero();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Reset mid-WAIT drops the transaction; a stray completion afterwards is ignored
        push_grant(0, 1'b1, 8'h55, 64'h0);
        request(0, 1'b1, 8'h55, 64'h0, 1'b1);
        idle(3);
        rst = 1'b1;
        check_zero();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        stray_pulse(64'h1111_2222_3333_4444);
        idle(4);

        // Contention straight after reset: rotation must start at requester 0
        push_grant(0, 1'b1, 8'h10, 64'h0);
        push_grant(1, 1'b1, 8'h20, 64'h0);
        push_grant(0, 1'b1, 8'h10, 64'h0);
        push_grant(1, 1'b1, 8'h20, 64'h0);
        req_r_wb  = 2'b11;
        req_addr  = {8'h20, 8'h10};
        req_wdata = '0;
        req_valid = 2'b11;
        bridge(0, 3, 1'b0, 64'hA0, 64'hA0);
        bridge(1, 2, 1'b0, 64'hB1, 64'hB1);
        bridge(0, 4, 1'b0, 64'hA2, 64'hA2);
        bridge(1, 3, 1'b0, 64'hB3, 64'hB3);
        req_valid = 2'b00;
        idle(4);

        // Single read by requester 0
        push_grant(0, 1'b1, 8'h1A, 64'h0);
        fork
            request(0, 1'b1, 8'h1A, 64'h0, 1'b1);
            bridge(0, 5, 1'b0, 64'hDEAD_BEEF, 64'hDEAD_BEEF);
        join
        idle(3);

        // Write by requester 1: read-data bus is ignored, response data is zero
        push_grant(1, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF);
        fork
            request(1, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b1);
            bridge(1, 4, 1'b0, 64'hFFFF_0000_FFFF_0000, 64'h0);
        join
        idle(3);

        // Silent bridge: watchdog aborts, then a late completion is ignored
        push_grant(0, 1'b1, 8'h33, 64'h0);
        fork
            request(0, 1'b1, 8'h33, 64'h0, 1'b1);
            bridge(0, 0, 1'b1, 64'h0, 64'h0);
        join
        idle(12);
        stray_pulse(64'h5555_6666_7777_8888);
        idle(3);

        // Completion in the last watchdog cycle wins over the abort
        push_grant(1, 1'b1, 8'h44, 64'h0);
        fork
            request(1, 1'b1, 8'h44, 64'h0, 1'b1);
            bridge(1, TO, 1'b0, 64'h0000_CAFE_F00D_0001, 64'h0000_CAFE_F00D_0001);
        join
        idle(5);

        check("grant_queue_empty", 64'(gq.size()), 64'd0);
        check("rsp_queue_empty", 64'(rq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
